// File: rtl/sev_seg_pkg.sv
// Shared types, hex segment table and sizing helper
// for the multiplexed seven-segment driver.
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        S_BLANK,
        S_ON
    } scan_state_t;

    // Active-high {g,f,e,d,c,b,a} patterns for hex 0-F
    localparam seg_t HEX_SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-high segment lookup.
module hex_to_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG_LUT[nibble];

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed N-digit hex seven-segment driver with
// dead time between slots and frame-synchronous updates.
module sev_seg_mux
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS         = 2,
    parameter int SLOT_CYCLES      = 24000,
    parameter int BLANK_CYCLES     = 240,
    parameter bit INPUT_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit AN_ACTIVE_LOW    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   digit_en_i,
    input  logic                  load_i,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int CW = clog2_min1(SLOT_CYCLES);
    localparam int IW = clog2_min1(N_DIGITS);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    scan_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] idx, idx_d;
    logic          frame_end;

    logic [4*N_DIGITS-1:0] act_dig, pend_dig;
    logic [N_DIGITS-1:0]   act_dp, pend_dp;
    logic [N_DIGITS-1:0]   act_en, pend_en;
    logic                  pend_valid;

    logic [3:0]          nib;
    seg_t                seg_hi;
    logic                lit;
    logic [N_DIGITS-1:0] sel;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        idx_d     = idx;
        frame_end = 1'b0;
        unique case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) state_d = S_ON;
            end
            S_ON: begin
                if (cnt == SLOT_LAST) begin
                    cnt_d     = '0;
                    state_d   = S_BLANK;
                    frame_end = (idx == IDX_LAST);
                    idx_d     = frame_end ? '0 : idx + IW'(1);
                end
            end
        endcase
    end

    // Active buffer only changes in the frame_tick cycle, so a frame never tears
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_dig    <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
        end else if (frame_tick) begin
            if (load_i) begin
                act_dig <= digits_i;
                act_dp  <= dp_i;
                act_en  <= digit_en_i;
            end else if (pend_valid) begin
                act_dig <= pend_dig;
                act_dp  <= pend_dp;
                act_en  <= pend_en;
            end
            pend_valid <= 1'b0;
        end else if (load_i) begin
            pend_dig   <= digits_i;
            pend_dp    <= dp_i;
            pend_en    <= digit_en_i;
            pend_valid <= 1'b1;
        end
    end

    assign nib = act_dig[{idx, 2'b00} +: 4] ^ {4{INPUT_ACTIVE_LOW}};
    assign lit = (state == S_ON) && act_en[idx];

    hex_to_seg u_dec (
        .nibble (nib),
        .seg    (seg_hi)
    );

    always_comb begin
        sel = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            sel[k] = lit && (idx == IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
            an         <= {N_DIGITS{AN_ACTIVE_LOW}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= (lit ? seg_hi : 7'd0) ^ {7{SEG_ACTIVE_LOW}};
            dp         <= (lit & act_dp[idx]) ^ SEG_ACTIVE_LOW;
            an         <= sel ^ {N_DIGITS{AN_ACTIVE_LOW}};
            frame_tick <= frame_end;
        end
    end

endmodule

// File: doc/sev_seg_mux.md
Name: sev_seg_mux

Overview:
- Parametrised, time-multiplexed N-digit hex seven-segment display driver.
- Scans one digit per time slot, with configurable dead time between slots to prevent ghosting.
- Configurable input, segment and anode polarity; tear-free value updates at frame boundaries.
- Sits between the keypad/datapath logic and the board's shared segment bus plus per-digit anode transistors.

Parameters:
- N_DIGITS, 2: number of multiplexed digits (>=1).
- SLOT_CYCLES, 24000: clock cycles per digit slot (blank + on time).
- BLANK_CYCLES, 240: dead-time cycles at slot start, all anodes off; must be < SLOT_CYCLES and >= 1.
- INPUT_ACTIVE_LOW, 1: 1 = input nibbles are inverted before decode (4'b1111 means 0).
- SEG_ACTIVE_LOW, 1: 1 = seg/dp outputs drive 0 to light a segment.
- AN_ACTIVE_LOW, 1: 1 = an outputs drive 0 to enable a digit.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- digits_i  input  4*N_DIGITS  digit k value = digits_i[4k+3:4k].
- dp_i  input  N_DIGITS  decimal point per digit, active-high.
- digit_en_i  input  N_DIGITS  per-digit enable; 0 = digit blanked, slot timing kept.
- load_i  input  1  capture digits_i/dp_i/digit_en_i into pending buffer.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW.
- an  output  N_DIGITS  digit anodes; bit k drives digit k, polarity per AN_ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse at end of every full scan.

Behaviour:
- Registers: slot counter cnt (0..SLOT_CYCLES-1), digit index idx (0..N_DIGITS-1), FSM state {S_BLANK, S_ON}, pending buffer + pend_valid flag, active display buffer.
- S_BLANK: held while cnt < BLANK_CYCLES; all anodes inactive, seg/dp inactive. At cnt == BLANK_CYCLES-1 -> S_ON.
- S_ON: an[idx] active iff active digit_en[idx]=1. seg = decode(active nibble idx), dp = active dp[idx]. At cnt == SLOT_CYCLES-1: cnt<=0, -> S_BLANK, idx<=idx+1.
- Wrap: at end of slot idx = N_DIGITS-1, idx wraps to 0 and frame_tick pulses high for exactly that cycle. Frame length = N_DIGITS*SLOT_CYCLES cycles.
- Load:
  - load_i=1 copies inputs to pending and sets pend_valid.
  - At frame end (the frame_tick cycle), if pend_valid: pending -> active, pend_valid cleared.
  - A later load_i before the frame end overwrites pending (last write wins).
  - load_i coincident with frame_tick: the new inputs go straight to active; pend_valid stays 0.
- Decode: nibble XOR {4{INPUT_ACTIVE_LOW}}, then hex 0-F, internal active-high. Active-low values: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- Outputs are registered: pins reflect FSM state one cycle after the state/cnt change (fixed latency 1, uniform for all outputs including frame_tick).
- Reset (reset_n=0 at a clk edge, any time including mid-slot):
  - cnt=0, idx=0, state=S_BLANK.
  - Active/pending buffers cleared; pend_valid=0; digit_en all 0.
  - Outputs inactive at the next edge: an all-inactive, seg/dp inactive (7'b1111111 / 1 when SEG_ACTIVE_LOW), frame_tick=0.
  - Display stays dark until the first load_i takes effect.
- N_DIGITS=1: idx width forced to 1 bit, idx stays 0, and frame_tick pulses every SLOT_CYCLES cycles.
- No combinational path from any input to any output.

Decomposition:
- Package sev_seg_pkg:
  - typedef seg_t (logic [6:0]).
  - typedef scan_state_t enum {S_BLANK, S_ON}.
  - constant HEX_SEG_LUT[16] of active-high patterns.
  - function clog2_min1.
- Sub-module hex_to_seg: combinational 4-bit nibble to active-high seg_t lookup using HEX_SEG_LUT.
- Polarity inversion stays in sev_seg_mux output registers.

Test Plan:
All scenarios use N_DIGITS=2, SLOT_CYCLES=8, BLANK_CYCLES=2, all polarity params=1.
- Reset dark: hold reset_n=0 for 3 cycles mid-scan, no load -> an=2'b11, seg=7'b1111111, dp=1 for 32+ cycles; frame_tick pulses every 16 cycles.
- Basic scan:
  - Stimulus: load digits_i=8'b0101_1111 (decoded A, 0), digit_en_i=2'b11, dp_i=2'b10.
  - After next frame: an=2'b10 with seg=1000000, dp=1 for 6 cycles; then 2 cycles an=2'b11; then an=2'b01 with seg=0001000, dp=0 for 6 cycles.
- Input polarity: nibble 4'b1111 -> seg=1000000 ("0"); nibble 4'b0000 -> seg=0001110 ("F").
- Tear-free load:
  - Stimulus: load a new value during digit 0's ON phase.
  - Digit 1 still shows the old value in that frame; both digits show the new value starting the cycle after frame_tick.
  - Two loads in one frame -> only the second is ever displayed.
- Digit disable: digit_en_i=2'b01 -> an[1] never active, an[0] timing unchanged, frame_tick period still 16.
- Coincident load: load_i asserted in the frame_tick cycle -> the new value is displayed in the immediately following frame.
